// File: rtl/mul_share_arb.sv
// Round-robin arbiter sharing one 8x8 unsigned multiplier between NUM_REQ requesters.
// Define MUL_PIPE_EN to add a register stage between operand capture and the output register.
module mul_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 res_valid,
  output logic [15:0]          res_data,
  output logic [ID_W-1:0]      res_id,
  input  logic                 res_ready,
  output logic [15:0]          op_count
);

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    win_id;
  logic               win_found;
  logic [NUM_REQ-1:0] grant;
  logic [7:0]         a_sel;
  logic [7:0]         b_sel;
  logic [15:0]        product;
  logic               can_accept;
  logic               accept;
  logic               out_free;
  logic               out_load;
  logic [15:0]        load_data;
  logic [ID_W-1:0]    load_id;
  logic [ID_W-1:0]    next_ptr;

  // Two passes: indices at/after the pointer first, then the wrapped ones.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_valid[i] && (ID_W'(i) >= rr_ptr)) begin
        win_found = 1'b1;
        win_id    = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_valid[i] && (ID_W'(i) < rr_ptr)) begin
        win_found = 1'b1;
        win_id    = ID_W'(i);
      end
    end
  end

  always_comb begin
    grant = '0;
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_id == ID_W'(i)) begin
        grant[i] = win_found;
        a_sel    = req_a[8*i +: 8];
        b_sel    = req_b[8*i +: 8];
      end
    end
  end

  assign product   = {8'b0, a_sel} * {8'b0, b_sel};
  assign out_free  = ~res_valid | res_ready;
  assign accept    = win_found & can_accept & rst_n;
  assign req_ready = grant & {NUM_REQ{can_accept & rst_n}};
  assign next_ptr  = (win_id == ID_W'(NUM_REQ - 1)) ? '0
                                                     : win_id + 1'b1;

`ifdef MUL_PIPE_EN
  logic            s1_valid;
  logic [15:0]     s1_data;
  logic [ID_W-1:0] s1_id;

  assign can_accept = ~s1_valid | out_free;
  assign out_load   = s1_valid & out_free;
  assign load_data  = s1_data;
  assign load_id    = s1_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_id    <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_data  <= product;
      s1_id    <= win_id;
    end else if (out_load) begin
      s1_valid <= 1'b0;
    end
  end
`else
  assign can_accept = out_free;
  assign out_load   = accept;
  assign load_data  = product;
  assign load_id    = win_id;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
    end else if (out_load) begin
      res_valid <= 1'b1;
      res_data  <= load_data;
      res_id    <= load_id;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= next_ptr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (res_valid && res_ready) begin
      op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_mul_share_arb.sv
// Randomized bench for mul_share_arb against a queue-based transaction model.
// Honours MUL_PIPE_EN for the expected latency and pipeline depth.
module tb_mul_share_arb;

`ifdef MUL_PIPE_EN
  localparam int LAT   = 2;
  localparam int DEPTH = 2;
`else
  localparam int LAT   = 1;
  localparam int DEPTH = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic [15:0] res_data;
  logic [1:0]  res_id;
  logic        res_ready;
  logic [15:0] op_count;

  mul_share_arb #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_ready (res_ready),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] p;
    int          id;
    int          t;
  } item_t;

  item_t       q[$];
  int          m_ptr;
  logic [15:0] m_cnt;
  int          cyc;
  int          n_cmp;
  int          n_bad;
  logic [3:0]  seen_rdy;
  logic        seen_vld;
  logic [15:0] seen_data;
  logic [1:0]  seen_id;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic step(input logic rst, input logic [3:0] v,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic rr);
    logic        exp_v;
    logic        drain;
    logic        can;
    int          win;
    logic [3:0]  exp_rdy;
    logic [31:0] sa;
    logic [31:0] sb;
    item_t       it;
    @(negedge clk);
    rst_n     = rst;
    req_valid = v;
    req_a     = a;
    req_b     = b;
    res_ready = rr;
    #1;
    seen_rdy  = req_ready;
    seen_vld  = res_valid;
    seen_data = res_data;
    seen_id   = res_id;
    if (!rst) begin
      chk("rst_ready", req_ready, 0);
      chk("rst_valid", res_valid, 0);
      chk("rst_count", op_count, 0);
      q.delete();
      m_ptr = 0;
      m_cnt = 0;
      cyc++;
      return;
    end
    exp_v = (q.size() > 0) && (cyc - q[0].t >= LAT);
    chk("res_valid", res_valid, exp_v);
    if (exp_v) begin
      chk("res_data", res_data, q[0].p);
      chk("res_id", res_id, q[0].id);
    end
    chk("op_count", op_count, m_cnt);
    drain = exp_v && rr;
    can   = (q.size() < DEPTH) || drain;
    win   = -1;
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (m_ptr + k) % 4;
      if (win < 0 && v[idx]) win = idx;
    end
    exp_rdy = (can && win >= 0) ? 4'(1 << win) : 4'd0;
    chk("req_ready", req_ready, exp_rdy);
    if (drain) begin
      void'(q.pop_front());
      m_cnt = m_cnt + 16'd1;
    end
    if (can && win >= 0) begin
      sa    = a >> (8 * win);
      sb    = b >> (8 * win);
      it.p  = 16'(sa[7:0]) * 16'(sb[7:0]);
      it.id = win;
      it.t  = cyc;
      q.push_back(it);
      m_ptr = (win + 1) % 4;
    end
    cyc++;
  endtask

  int rr_exp[6] = '{1, 2, 4, 8, 1, 2};
  int guard;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    m_ptr = 0;
    m_cnt = 0;
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    res_ready = 1'b0;
    repeat (3) step(1'b0, 4'h0, 0, 0, 1'b0);

    // single operation and its latency
    step(1'b1, 4'b0001, 32'h05, 32'h07, 1'b1);
    chk("single_rdy", seen_rdy, 4'b0001);
    repeat (LAT) step(1'b1, 4'h0, 0, 0, 1'b1);
    chk("single_vld", seen_vld, 1);
    chk("single_data", seen_data, 35);
    chk("single_id", seen_id, 0);
    step(1'b1, 4'h0, 0, 0, 1'b1);
    chk("single_cnt", op_count, 1);

    // round robin from a fresh reset
    step(1'b0, 4'h0, 0, 0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 4'hF, $urandom, $urandom, 1'b1);
      chk("rr_order", seen_rdy, rr_exp[i]);
    end
    repeat (3) step(1'b1, 4'h0, 0, 0, 1'b1);

    // corner products
    step(1'b1, 4'b0111, 32'h00_80_00_FF, 32'h00_02_C8_FF, 1'b1);
    step(1'b1, 4'b0111, 32'h00_80_00_FF, 32'h00_02_C8_FF, 1'b1);
    step(1'b1, 4'b0111, 32'h00_80_00_FF, 32'h00_02_C8_FF, 1'b1);
    repeat (3) step(1'b1, 4'h0, 0, 0, 1'b1);

    // backpressure
    for (int i = 0; i < 5; i++)
      step(1'b1, 4'b0110, $urandom, $urandom, 1'b0);
    chk("bp_full", seen_rdy, 0);
    chk("bp_vld", seen_vld, 1);
    repeat (4) step(1'b1, 4'h0, 0, 0, 1'b1);
    chk("bp_empty", q.size(), 0);

    // reset the cycle after an accept
    step(1'b1, 4'b1000, $urandom, $urandom, 1'b1);
    step(1'b0, 4'hF, 0, 0, 1'b1);
    step(1'b0, 4'hF, 0, 0, 1'b1);
    step(1'b1, 4'h0, 0, 0, 1'b1);
    chk("post_rst_vld", seen_vld, 0);
    step(1'b1, 4'hF, $urandom, $urandom, 1'b1);
    chk("post_rst_grant", seen_rdy, 4'b0001);
    repeat (3) step(1'b1, 4'h0, 0, 0, 1'b1);

    // random traffic
    for (int i = 0; i < 2000; i++)
      step(1'b1, 4'($urandom), $urandom, $urandom,
           1'($urandom_range(0, 3) != 0));
    repeat (4) step(1'b1, 4'h0, 0, 0, 1'b1);
    chk("rand_empty", q.size(), 0);

    // counter wrap
    guard = 0;
    while (m_cnt != 16'hFFFF && guard < 70000) begin
      step(1'b1, 4'b0100, $urandom, $urandom, 1'b1);
      guard++;
    end
    chk("wrap_reach", m_cnt, 16'hFFFF);
    guard = 0;
    while (m_cnt != 16'h0000 && guard < 8) begin
      step(1'b1, 4'b0100, $urandom, $urandom, 1'b1);
      guard++;
    end
    @(posedge clk);
    #1;
    chk("wrap", op_count, m_cnt);
    chk("wrap_zero", m_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
